// File: rtl/y86_fetch_unit.sv
// Multi-cycle Y86-64 instruction fetch stage.
// Reads instruction bytes one at a time over a byte-wide req/ack memory port.
// It decodes icode/ifun/rA/rB/valC, computes valP, and presents the result
// with a valid/ready handshake.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   PC, start                   fetch address and request (sampled in IDLE)
//   mem_req/mem_addr            byte read request and address
//   mem_ack/mem_rdata/mem_err   read completion, data, fault
//   f_valid/f_ready             result handshake
//   icode, ifun, rA, rB, valC, valP                 decoded instruction
//   imem_error, instr_invalid, halt                 status
module y86_fetch_unit #(
  parameter int unsigned MEM_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] PC,
  input  logic        start,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        imem_error,
  output logic        instr_invalid,
  output logic        halt
);

  localparam int unsigned AW = 64;
  localparam int unsigned KW = 4;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  // Instruction length in bytes by icode; invalid opcodes occupy one byte.
  function automatic logic [KW-1:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = KW'(1);
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = KW'(2);
      4'h7, 4'h8:             instr_len = KW'(9);
      4'h3, 4'h4, 4'h5:       instr_len = KW'(10);
      default:                instr_len = KW'(1);
    endcase
  endfunction

  // Whether byte 1 is a register specifier.
  function automatic logic has_regb(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regb = 1'b1;
      default:                                  has_regb = 1'b0;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [KW-1:0] k_q, k_d;

  logic          mem_req_d;
  logic [AW-1:0] mem_addr_d;
  logic          f_valid_d;
  logic [3:0]    icode_d, ifun_d, rA_d, rB_d;
  logic [63:0]   valC_d, valP_d;
  logic          imem_error_d, instr_invalid_d, halt_d;

  // Shared fetch-progress decode.
  logic [3:0]    cur_icode;
  logic [KW-1:0] cur_len;
  logic          byte_ok, byte_err, no_req, last_byte;
  logic [AW-1:0] next_addr;
  logic          next_oob, start_oob;
  logic [2:0]    valc_idx;

  // Byte 0 supplies the icode in the same cycle it arrives.
  assign cur_icode = (k_q == '0) ? mem_rdata[7:4] : icode;
  assign cur_len   = instr_len(cur_icode);
  assign byte_ok   = (state_q == FETCH) && mem_req && mem_ack && !mem_err;
  assign byte_err  = (state_q == FETCH) && mem_req && mem_ack && mem_err;
  // FETCH without an outstanding request means the range check tripped.
  assign no_req    = (state_q == FETCH) && !mem_req;
  assign last_byte = byte_ok && (k_q == KW'(cur_len - KW'(1)));
  assign next_addr = base_q + AW'(k_q) + AW'(1);
  assign next_oob  = next_addr >= AW'(MEM_LIMIT);
  assign start_oob = PC >= AW'(MEM_LIMIT);
  // valC byte position follows the optional register byte.
  assign valc_idx  = 3'(k_q - (has_regb(icode) ? KW'(2) : KW'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last_byte || byte_err || no_req) state_d = DONE;
      DONE:    if (f_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and fetch context.
  always_comb begin
    base_d          = base_q;
    k_d             = k_q;
    mem_req_d       = mem_req;
    mem_addr_d      = mem_addr;
    f_valid_d       = f_valid;
    icode_d         = icode;
    ifun_d          = ifun;
    rA_d            = rA;
    rB_d            = rB;
    valC_d          = valC;
    valP_d          = valP;
    imem_error_d    = imem_error;
    instr_invalid_d = instr_invalid;
    halt_d          = halt;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d          = PC;
          k_d             = '0;
          mem_addr_d      = PC;
          mem_req_d       = !start_oob;
          icode_d         = 4'h1;
          ifun_d          = 4'h0;
          rA_d            = 4'hF;
          rB_d            = 4'hF;
          valC_d          = '0;
          imem_error_d    = 1'b0;
          instr_invalid_d = 1'b0;
          halt_d          = 1'b0;
        end
      end
      FETCH: begin
        if (no_req || byte_err) begin
          // Faulted fetch is reported as a nop at the original PC.
          mem_req_d       = 1'b0;
          f_valid_d       = 1'b1;
          icode_d         = 4'h1;
          ifun_d          = 4'h0;
          rA_d            = 4'hF;
          rB_d            = 4'hF;
          valC_d          = '0;
          valP_d          = base_q;
          imem_error_d    = 1'b1;
          instr_invalid_d = 1'b0;
          halt_d          = 1'b0;
        end else if (byte_ok) begin
          if (k_q == '0) begin
            icode_d = mem_rdata[7:4];
            ifun_d  = mem_rdata[3:0];
          end else if (has_regb(icode) && (k_q == KW'(1))) begin
            rA_d = mem_rdata[7:4];
            rB_d = mem_rdata[3:0];
          end else begin
            valC_d[{valc_idx, 3'b000} +: 8] = mem_rdata;
          end
          if (last_byte) begin
            mem_req_d       = 1'b0;
            f_valid_d       = 1'b1;
            valP_d          = base_q + AW'(cur_len);
            instr_invalid_d = cur_icode > 4'hB;
            halt_d          = cur_icode == 4'h0;
          end else begin
            k_d        = KW'(k_q + KW'(1));
            mem_addr_d = next_addr;
            mem_req_d  = !next_oob;
          end
        end
      end
      DONE: begin
        if (f_ready) f_valid_d = 1'b0;
      end
      default: begin
        mem_req_d = 1'b0;
        f_valid_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and fetch context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q        <= '0;
      k_q           <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      f_valid       <= 1'b0;
      icode         <= 4'h1;
      ifun          <= 4'h0;
      rA            <= 4'hF;
      rB            <= 4'hF;
      valC          <= '0;
      valP          <= '0;
      imem_error    <= 1'b0;
      instr_invalid <= 1'b0;
      halt          <= 1'b0;
    end else begin
      base_q        <= base_d;
      k_q           <= k_d;
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
      f_valid       <= f_valid_d;
      icode         <= icode_d;
      ifun          <= ifun_d;
      rA            <= rA_d;
      rB            <= rB_d;
      valC          <= valC_d;
      valP          <= valP_d;
      imem_error    <= imem_error_d;
      instr_invalid <= instr_invalid_d;
      halt          <= halt_d;
    end
  end

endmodule
